calc_alu_sequencer: RTL and testbench

- Controller that owns the 8-bit ALU in the calculator datapath and sequences it.
- It accepts one calculator command at a time.
- Single-step ops (ADD, SUB, AND, OR, SLT) go through the ALU in one pass.
- MUL is an unsigned 8x8 shift-add and DIV is an unsigned restoring divide. Both iterate 8 times through the same ALU, and the sequencer holds the 16-bit working registers.

---
 rtl/calc_alu_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_calc_alu_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/calc_alu_sequencer.sv
// calc_alu_sequencer
//   Owns the calculator's 8-bit ALU. It takes one command at a time. ADD/SUB/
//   AND/OR/SLT finish in a single ALU pass. MUL (shift-add) and DIV (restoring)
//   run WIDTH iterations through the same ALU, with the 16-bit working pair
//   {hi,lo} held here.
// Ports
//   clock, reset_n        rising-edge clock, synchronous active-low reset
//   start, cmd, op_a/b    command strobe (taken in IDLE or DONE), opcode, operands
//   alu_a/b/operation     drive the external ALU (all zero when idle)
//   alu_result/carry_out/overflow  ALU response, same cycle
//   busy, done            busy in EXEC/MUL/DIV; done is a one-cycle pulse
//   result, result_hi     low byte/quotient, high byte/remainder
//   carry, overflow, zero, error   completion flags, held until the next start
module calc_alu_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       cmd,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_operation,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry_out,
  input  logic             alu_overflow,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             error
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] C_ADD = 3'd0, C_SUB = 3'd1, C_AND = 3'd2, C_OR = 3'd3,
                         C_SLT = 3'd4, C_MUL = 3'd5, C_DIV = 3'd6;

  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_MUL, S_DIV, S_DONE} state_t;

  state_t           state, state_n;
  logic [2:0]       cmd_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] hi, lo;   // MUL: product hi/lo ; DIV: remainder/quotient
  logic [CW-1:0]    cnt;
  logic             res_valid; // a result has been produced since the last start

  logic             accept, last;
  logic             mul_c;
  logic [WIDTH-1:0] mul_sum, mul_hi_n, mul_lo_n;
  logic [WIDTH:0]   r9;
  logic             div_take;
  logic [WIDTH-1:0] div_rem_n, div_q_n;

  assign accept = start && (state == S_IDLE || state == S_DONE);
  assign last   = (cnt == CW'(WIDTH - 1));

  // Shift-add step: add the multiplicand only when the multiplier LSB is set,
  // then shift the 17-bit {carry,hi,lo} right by one.
  assign mul_c    = lo[0] & alu_carry_out;
  assign mul_sum  = lo[0] ? alu_result : hi;
  assign mul_hi_n = {mul_c, mul_sum[WIDTH-1:1]};
  assign mul_lo_n = {mul_sum[0], lo[WIDTH-1:1]};

  // Restoring divide step: shift the next dividend bit into the remainder.
  // The shifted remainder is 9 bits; if its top bit is set it is certainly
  // >= divisor even though the 8-bit subtraction borrows.
  assign r9        = {hi, lo[WIDTH-1]};
  assign div_take  = r9[WIDTH] | alu_carry_out;
  assign div_rem_n = div_take ? alu_result : r9[WIDTH-1:0];
  assign div_q_n   = {lo[WIDTH-2:0], div_take};

  always_ff @(posedge clock) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n       = state;
    alu_a         = '0;
    alu_b         = '0;
    alu_operation = 4'b0000;
    case (state)
      S_IDLE, S_DONE: begin
        state_n = S_IDLE;
        if (accept) begin
          if (cmd <= C_SLT)      state_n = S_EXEC;
          else if (cmd == C_MUL) state_n = S_MUL;
          else if (cmd == C_DIV) state_n = (op_b == '0) ? S_DONE : S_DIV;
          else                   state_n = S_DONE;
        end
      end
      S_EXEC: begin
        state_n = S_DONE;
        alu_a   = a_q;
        alu_b   = b_q;
        case (cmd_q)
          C_ADD:   alu_operation = 4'b0010;
          C_SUB:   alu_operation = 4'b0110;
          C_AND:   alu_operation = 4'b0000;
          C_OR:    alu_operation = 4'b0001;
          default: alu_operation = 4'b0111;
        endcase
      end
      S_MUL: begin
        if (last) state_n = S_DONE;
        alu_a         = hi;
        alu_b         = a_q;
        alu_operation = 4'b0010;
      end
      S_DIV: begin
        if (last) state_n = S_DONE;
        alu_a         = r9[WIDTH-1:0];
        alu_b         = b_q;
        alu_operation = 4'b0110;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cmd_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      hi        <= '0;
      lo        <= '0;
      cnt       <= '0;
      result    <= '0;
      result_hi <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      error     <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (accept) begin
          cmd_q     <= cmd;
          a_q       <= op_a;
          b_q       <= op_b;
          cnt       <= '0;
          carry     <= 1'b0;
          overflow  <= 1'b0;
          error     <= 1'b0;
          res_valid <= 1'b0;
          if (cmd == C_MUL) begin
            hi <= '0;
            lo <= op_b;
          end else if (cmd == C_DIV && op_b != '0) begin
            hi <= '0;
            lo <= op_a;
          end else if (cmd == C_DIV) begin
            error     <= 1'b1;
            result    <= '1;
            result_hi <= op_a;
            res_valid <= 1'b1;
          end else if (cmd > C_DIV) begin
            error     <= 1'b1;
            result    <= '0;
            result_hi <= '0;
            res_valid <= 1'b1;
          end
        end
        S_EXEC: begin
          result    <= alu_result;
          result_hi <= '0;
          res_valid <= 1'b1;
          if (cmd_q == C_ADD || cmd_q == C_SUB) begin
            carry    <= alu_carry_out;
            overflow <= alu_overflow;
          end
        end
        S_MUL: begin
          hi  <= mul_hi_n;
          lo  <= mul_lo_n;
          cnt <= cnt + 1'b1;
          if (last) begin
            result    <= mul_lo_n;
            result_hi <= mul_hi_n;
            overflow  <= (mul_hi_n != '0);
            res_valid <= 1'b1;
          end
        end
        S_DIV: begin
          hi  <= div_rem_n;
          lo  <= div_q_n;
          cnt <= cnt + 1'b1;
          if (last) begin
            result    <= div_q_n;
            result_hi <= div_rem_n;
            res_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == S_EXEC) || (state == S_MUL) || (state == S_DIV);
  assign done = (state == S_DONE);
  assign zero = res_valid && ({result_hi, result} == '0);

endmodule

// File: tb/tb_calc_alu_sequencer.sv
module tb_calc_alu_sequencer;
  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] cmd = 3'd0;
  logic [7:0] op_a = 8'd0, op_b = 8'd0;
  logic [7:0] alu_a, alu_b, alu_result;
  logic [3:0] alu_operation;
  logic       alu_carry_out, alu_overflow;
  logic       busy, done, carry, overflow, zero, error;
  logic [7:0] result, result_hi;

  calc_alu_sequencer #(.WIDTH(8)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .cmd(cmd),
    .op_a(op_a), .op_b(op_b), .alu_a(alu_a), .alu_b(alu_b),
    .alu_operation(alu_operation), .alu_result(alu_result),
    .alu_carry_out(alu_carry_out), .alu_overflow(alu_overflow),
    .busy(busy), .done(done), .result(result), .result_hi(result_hi),
    .carry(carry), .overflow(overflow), .zero(zero), .error(error)
  );

  always #5 clock = ~clock;

  // MIPS-style ALU the sequencer drives.
  logic [7:0] ia, ib;
  logic [8:0] s;
  always_comb begin
    ia = alu_operation[3] ? ~alu_a : alu_a;
    ib = alu_operation[2] ? ~alu_b : alu_b;
    s  = {1'b0, ia} + {1'b0, ib} + {8'd0, alu_operation[2]};
    alu_carry_out = s[8];
    alu_overflow  = (ia[7] == ib[7]) && (s[7] != ia[7]);
    case (alu_operation[1:0])
      2'b00:   alu_result = ia & ib;
      2'b01:   alu_result = ia | ib;
      2'b10:   alu_result = s[7:0];
      default: alu_result = {7'd0, s[7] ^ alu_overflow};
    endcase
  end

  typedef struct {
    logic [7:0] r, rh;
    logic       c, o, z, e;
    int         due;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Reference: plain arithmetic on the command's meaning. due holds extra edges.
  function automatic exp_t model(input logic [2:0] c, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int   sum, p;
    e.r = 0; e.rh = 0; e.c = 0; e.o = 0; e.e = 0; e.due = 1;
    case (c)
      3'd0: begin
        sum = int'(a) + int'(b);
        e.r = sum[7:0]; e.c = (sum > 255);
        e.o = ($signed(a) + $signed(b) > 127) || ($signed(a) + $signed(b) < -128);
      end
      3'd1: begin
        sum = int'(a) - int'(b);
        e.r = sum[7:0]; e.c = (a >= b);
        e.o = (int'($signed(a)) - int'($signed(b)) > 127) || (int'($signed(a)) - int'($signed(b)) < -128);
      end
      3'd2: e.r = a & b;
      3'd3: e.r = a | b;
      3'd4: e.r = ($signed(a) < $signed(b)) ? 8'd1 : 8'd0;
      3'd5: begin
        p = int'(a) * int'(b);
        e.r = p[7:0]; e.rh = p[15:8]; e.o = (p > 255); e.due = 8;
      end
      3'd6: begin
        if (b == 0) begin
          e.r = 8'hFF; e.rh = a; e.e = 1; e.due = 0;
        end else begin
          e.r = a / b; e.rh = a % b; e.due = 8;
        end
      end
      default: begin
        e.e = 1; e.due = 0;
      end
    endcase
    e.z = ({e.rh, e.r} == 16'd0);
    return e;
  endfunction

  // Monitor: every Done pulse is matched against the oldest expectation.
  always @(negedge clock) begin
    if (reset_n && done) begin
      if (q.size() == 0) begin
        errors++; checks++;
        $display("FAIL unexpected_done: done=1 with no pending command at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        checks++;
        if ({result, result_hi, carry, overflow, zero, error} !== {e.r, e.rh, e.c, e.o, e.z, e.e}) begin
          errors++;
          $display("FAIL result: got r=%h rh=%h c=%b o=%b z=%b e=%b, want r=%h rh=%h c=%b o=%b z=%b e=%b",
                   result, result_hi, carry, overflow, zero, error, e.r, e.rh, e.c, e.o, e.z, e.e);
        end
        checks++;
        if (cyc != e.due) begin
          errors++;
          $display("FAIL latency: done at cycle %0d, want %0d", cyc, e.due);
        end
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL busy_in_done: got %b want 0", busy);
        end
      end
    end
  end

  task automatic push_exp(input logic [2:0] c, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    e = model(c, a, b);
    e.due = cyc + 1 + e.due;
    q.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (q.size() != 0 && n < 40) begin
      @(posedge clock);
      n++;
    end
    if (q.size() != 0) begin
      errors++; checks++;
      $display("FAIL timeout: %0d responses still pending", q.size());
      q.delete();
    end
  endtask

  task automatic issue(input logic [2:0] c, input logic [7:0] a, input logic [7:0] b, input bit wait_done);
    @(negedge clock);
    cmd = c; op_a = a; op_b = b; start = 1'b1;
    push_exp(c, a, b);
    @(negedge clock);
    start = 1'b0;
    if (wait_done) wait_idle();
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({busy, done, result, result_hi, carry, overflow, zero, error, alu_a, alu_b, alu_operation} !== '0) begin
      errors++;
      $display("FAIL %s: busy=%b done=%b r=%h rh=%h c=%b o=%b z=%b e=%b alu_a=%h alu_b=%h op=%h, want all 0",
               name, busy, done, result, result_hi, carry, overflow, zero, error, alu_a, alu_b, alu_operation);
    end
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check_all_zero("reset_state");
    reset_n = 1'b1;

    issue(3'd0, 8'h7F, 8'h01, 1);
    issue(3'd1, 8'd5, 8'd5, 1);
    issue(3'd5, 8'hFF, 8'hFF, 1);
    issue(3'd5, 8'd12, 8'd10, 1);
    issue(3'd6, 8'd200, 8'd7, 1);
    issue(3'd6, 8'd255, 8'd1, 1);
    issue(3'd6, 8'd9, 8'd0, 1);
    issue(3'd7, 8'd3, 8'd4, 1);
    issue(3'd2, 8'hF0, 8'h3C, 1);
    issue(3'd3, 8'hF0, 8'h0C, 1);

    // Start pulse while MUL is busy must be ignored.
    issue(3'd5, 8'd13, 8'd11, 0);
    @(negedge clock);
    cmd = 3'd0; op_a = 8'h11; op_b = 8'h22; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_idle();

    // Back-to-back: new Start on the DONE cycle.
    issue(3'd5, 8'd7, 8'd9, 0);
    begin
      int n = 0;
      while (!done && n < 20) begin
        @(negedge clock);
        n++;
      end
      if (!done) begin
        errors++; checks++;
        $display("FAIL b2b_done: done never seen, got 0 want 1");
      end
      cmd = 3'd4; op_a = 8'd3; op_b = 8'd5; start = 1'b1;
      push_exp(3'd4, 8'd3, 8'd5);
      @(negedge clock);
      start = 1'b0;
      wait_idle();
    end

    // Reset in the middle of a MUL.
    issue(3'd5, 8'hA5, 8'h5A, 0);
    repeat (3) @(negedge clock);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_mid_mul: got %b want 1", busy);
    end
    reset_n = 1'b0;
    q.delete();
    @(negedge clock);
    check_all_zero("mid_op_reset");
    reset_n = 1'b1;
    issue(3'd0, 8'd1, 8'd1, 1);

    // Random commands, DIV by zero made more likely.
    for (int i = 0; i < 150; i++) begin
      logic [2:0] c;
      logic [7:0] a, b;
      c = 3'($urandom_range(0, 7));
      a = 8'($urandom);
      b = 8'($urandom);
      if (c == 3'd6 && $urandom_range(0, 5) == 0) b = 8'd0;
      issue(c, a, b, 1);
    end

    repeat (2) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
